// File: rtl/sdram_port_arbiter.sv
// Arbitrates N buffered front-end ports onto one SDRAM controller port, with an
// IDLE/OWN/DRAIN ownership FSM, per-grant access limit and write snooping for non-owners.
module sdram_port_arbiter #(
    parameter int    PORTS     = 3,
    parameter int    ADR_WIDTH = 32,
    parameter int    DAT_WIDTH = 32,
    parameter string MODE      = "RR",
    parameter int    MAX_GRANT = 8
) (
    input  logic                       sdram_clk,
    input  logic                       sdram_rst,
    input  logic                       sdram_idle_i,
    input  logic [PORTS*ADR_WIDTH-1:0] p_adr_i,
    input  logic [PORTS*DAT_WIDTH-1:0] p_dat_i,
    input  logic [PORTS*DAT_WIDTH/8-1:0] p_sel_i,
    input  logic [PORTS-1:0]           p_we_i,
    input  logic [PORTS-1:0]           p_acc_i,
    input  logic [PORTS*4-1:0]         p_bufw_i,
    output logic [PORTS-1:0]           p_ack_o,
    output logic [ADR_WIDTH-1:0]       adr_o,
    output logic [DAT_WIDTH-1:0]       dat_o,
    output logic [DAT_WIDTH/8-1:0]     sel_o,
    output logic                       we_o,
    output logic                       acc_o,
    output logic [3:0]                 buf_width_o,
    input  logic                       ack_i,
    output logic [PORTS-1:0]           grant_o,
    output logic [PORTS-1:0]           snp_we_o,
    output logic [ADR_WIDTH-1:0]       snp_adr_o,
    output logic [DAT_WIDTH-1:0]       snp_dat_o,
    output logic [DAT_WIDTH/8-1:0]     snp_sel_o,
    output logic [1:0]                 state_o
);
    localparam int SW = DAT_WIDTH / 8;
    localparam int CW = (MAX_GRANT > 0) ? $clog2(MAX_GRANT + 1) : 1;
    localparam bit IS_PRIO = (MODE == "PRIO");

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t           state_q;
    logic [PORTS-1:0] grant_q;
    logic [PORTS-1:0] grant_d;
    logic [CW-1:0]    count_q;
    logic [PORTS-1:0] snp_we_q;
    logic [ADR_WIDTH-1:0] snp_adr_q;
    logic [DAT_WIDTH-1:0] snp_dat_q;
    logic [SW-1:0]    snp_sel_q;
    logic             own_acc;
    logic             others_acc;
    logic             at_limit;
    logic             limit_hit;

    // RR rotates the request vector so the search starts just after the owner;
    // PRIO uses a zero rotation, giving plain lowest-index-wins.
    function automatic logic [PORTS-1:0] pick_f(input logic [PORTS-1:0] req,
                                                input logic [PORTS-1:0] cur);
        logic [PORTS-1:0] rot;
        logic [PORTS-1:0] oh;
        logic [PORTS-1:0] res;
        logic             found;
        int               own;
        int               sh;
        own = 0;
        for (int k = 0; k < PORTS; k++) if (cur[k]) own = k;
        sh    = IS_PRIO ? 0 : own + 1;
        rot   = PORTS'({req, req} >> sh);
        oh    = '0;
        found = 1'b0;
        for (int j = 0; j < PORTS; j++) begin
            if (!found && rot[j]) begin
                oh[j] = 1'b1;
                found = 1'b1;
            end
        end
        res = found ? PORTS'(({oh, oh} << sh) >> PORTS) : cur;
        return res;
    endfunction

    always_comb begin
        adr_o       = '0;
        dat_o       = '0;
        sel_o       = '0;
        we_o        = 1'b0;
        buf_width_o = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (grant_q[k]) begin
                adr_o       = p_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
                dat_o       = p_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
                sel_o       = p_sel_i[k*SW +: SW];
                we_o        = p_we_i[k];
                buf_width_o = p_bufw_i[k*4 +: 4];
            end
        end
    end

    assign own_acc    = |(p_acc_i & grant_q);
    assign others_acc = |(p_acc_i & ~grant_q);
    assign at_limit   = (MAX_GRANT != 0) && (count_q == CW'(MAX_GRANT));
    assign limit_hit  = at_limit && others_acc;
    assign grant_d    = pick_f(p_acc_i, grant_q);

    assign acc_o     = own_acc && (state_q == S_OWN) && !limit_hit;
    assign p_ack_o   = {PORTS{ack_i}} & grant_q;
    assign grant_o   = grant_q;
    assign snp_we_o  = snp_we_q;
    assign snp_adr_o = snp_adr_q;
    assign snp_dat_o = snp_dat_q;
    assign snp_sel_o = snp_sel_q;
    assign state_o   = state_q;

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q   <= S_IDLE;
            grant_q   <= PORTS'(1);
            count_q   <= '0;
            snp_we_q  <= '0;
            snp_adr_q <= '0;
            snp_dat_q <= '0;
            snp_sel_q <= '0;
        end else begin
            // Completed writes from the owner invalidate/update every other port's buffer.
            if (ack_i && we_o) begin
                snp_we_q  <= ~grant_q;
                snp_adr_q <= adr_o;
                snp_dat_q <= dat_o;
                snp_sel_q <= sel_o;
            end else begin
                snp_we_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (sdram_idle_i && |p_acc_i) begin
                        grant_q <= grant_d;
                        count_q <= '0;
                        state_q <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (at_limit && !others_acc) count_q <= CW'(ack_i);
                    else if (ack_i && !at_limit && (MAX_GRANT != 0)) count_q <= count_q + CW'(1);
                    if (limit_hit || (!own_acc && !ack_i)) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (sdram_idle_i) begin
                        if (|p_acc_i) begin
                            grant_q <= grant_d;
                            count_q <= '0;
                            state_q <= S_OWN;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: three arbiter instances (RR limit 2, PRIO limit 2, RR unlimited) share
// port stimulus; ack/snoop scoreboards plus directed FSM/mux checks.
module tb_sdram_port_arbiter;
  logic clk, rst, idle;
  logic [95:0] p_adr, p_dat;
  logic [11:0] p_sel, p_bufw;
  logic [2:0] p_we, p_acc, ctl_en;
  logic ack_a, ack_b, ack_c, rr_watch;

  logic [2:0] a_p_ack, a_grant, a_snp_we, b_p_ack, b_grant, b_snp_we, c_p_ack, c_grant, c_snp_we;
  logic [31:0] a_adr, a_dat, a_snp_adr, a_snp_dat, b_adr, b_dat, b_snp_adr, b_snp_dat;
  logic [31:0] c_adr, c_dat, c_snp_adr, c_snp_dat;
  logic [3:0] a_sel, a_bufw, a_snp_sel, b_sel, b_bufw, b_snp_sel, c_sel, c_bufw, c_snp_sel;
  logic a_we, a_acc, b_we, b_acc, c_we, c_acc;
  logic [1:0] a_state, b_state, c_state;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0]  a_q[$];
  logic [2:0]  b_q[$];
  logic [2:0]  c_q[$];
  logic [70:0] snp_q[$];

  sdram_port_arbiter #(.PORTS(3), .MODE("RR"), .MAX_GRANT(2)) u_rr (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle), .p_adr_i(p_adr), .p_dat_i(p_dat),
    .p_sel_i(p_sel), .p_we_i(p_we), .p_acc_i(p_acc), .p_bufw_i(p_bufw), .p_ack_o(a_p_ack),
    .adr_o(a_adr), .dat_o(a_dat), .sel_o(a_sel), .we_o(a_we), .acc_o(a_acc),
    .buf_width_o(a_bufw), .ack_i(ack_a), .grant_o(a_grant), .snp_we_o(a_snp_we),
    .snp_adr_o(a_snp_adr), .snp_dat_o(a_snp_dat), .snp_sel_o(a_snp_sel), .state_o(a_state));

  sdram_port_arbiter #(.PORTS(3), .MODE("PRIO"), .MAX_GRANT(2)) u_pr (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle), .p_adr_i(p_adr), .p_dat_i(p_dat),
    .p_sel_i(p_sel), .p_we_i(p_we), .p_acc_i(p_acc), .p_bufw_i(p_bufw), .p_ack_o(b_p_ack),
    .adr_o(b_adr), .dat_o(b_dat), .sel_o(b_sel), .we_o(b_we), .acc_o(b_acc),
    .buf_width_o(b_bufw), .ack_i(ack_b), .grant_o(b_grant), .snp_we_o(b_snp_we),
    .snp_adr_o(b_snp_adr), .snp_dat_o(b_snp_dat), .snp_sel_o(b_snp_sel), .state_o(b_state));

  sdram_port_arbiter #(.PORTS(3), .MODE("RR"), .MAX_GRANT(0)) u_un (
    .sdram_clk(clk), .sdram_rst(rst), .sdram_idle_i(idle), .p_adr_i(p_adr), .p_dat_i(p_dat),
    .p_sel_i(p_sel), .p_we_i(p_we), .p_acc_i(p_acc), .p_bufw_i(p_bufw), .p_ack_o(c_p_ack),
    .adr_o(c_adr), .dat_o(c_dat), .sel_o(c_sel), .we_o(c_we), .acc_o(c_acc),
    .buf_width_o(c_bufw), .ack_i(ack_c), .grant_o(c_grant), .snp_we_o(c_snp_we),
    .snp_adr_o(c_snp_adr), .snp_dat_o(c_snp_dat), .snp_sel_o(c_snp_sel), .state_o(c_state));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: one ack in the cycle after it sees a request, then one busy cycle.
  initial begin
    logic na, nb, nc;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    forever begin
      @(negedge clk);
      na = !rst && ctl_en[0] && a_acc && !ack_a;
      nb = !rst && ctl_en[1] && b_acc && !ack_b;
      nc = !rst && ctl_en[2] && c_acc && !ack_c;
      @(posedge clk);
      #1;
      ack_a = na; ack_b = nb; ack_c = nc;
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    logic [2:0]  e;
    logic [70:0] s;
    if (!rst) begin
      if (|a_p_ack) begin
        if (a_q.size() == 0) check("rr_ack_extra", a_p_ack, 3'b000);
        else begin e = a_q.pop_front(); check("rr_ack", {a_grant, a_p_ack}, {e, e}); end
      end
      if (|b_p_ack) begin
        if (b_q.size() == 0) check("prio_ack_extra", b_p_ack, 3'b000);
        else begin e = b_q.pop_front(); check("prio_ack", {b_grant, b_p_ack}, {e, e}); end
      end
      if (|c_p_ack) begin
        if (c_q.size() == 0) check("unl_ack_extra", c_p_ack, 3'b000);
        else begin e = c_q.pop_front(); check("unl_ack", {c_grant, c_p_ack}, {e, e}); end
      end
      if (|a_snp_we) begin
        if (snp_q.size() == 0) check("snoop_extra", a_snp_we, 3'b000);
        else begin s = snp_q.pop_front(); check("snoop", {a_snp_we, a_snp_adr, a_snp_dat, a_snp_sel}, s); end
      end
    end
  end

  logic [2:0] prev_grant;
  logic       prev_acc;
  always @(negedge clk) begin
    if (rr_watch && !rst && a_grant != prev_grant) check("rr_gap_acc", prev_acc, 1'b0);
    prev_grant <= a_grant;
    prev_acc   <= a_acc;
  end

  // driver tasks
  function automatic int qsize(input int which);
    if (which == 0) return a_q.size();
    if (which == 1) return b_q.size();
    return c_q.size();
  endfunction

  task automatic wait_q(input int which, input int target, input int budget);
    int sz;
    sz = qsize(which);
    for (int i = 0; i < budget && sz > target; i++) begin
      @(posedge clk); #1;
      sz = qsize(which);
    end
    check("wait_q", sz, target);
  endtask

  task automatic reset_all();
    @(posedge clk); #1;
    rst = 1'b1; p_acc = 3'b000; ctl_en = 3'b000; idle = 1'b1; p_we = 3'b000;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_rr", {a_state, a_grant, a_acc, a_snp_we, a_snp_adr}, {2'd0, 3'b001, 1'b0, 3'b000, 32'h0});
    check("rst_pr", {b_state, b_grant, b_acc, b_snp_we}, {2'd0, 3'b001, 1'b0, 3'b000});
    check("rst_un", {c_state, c_grant, c_acc, c_snp_we}, {2'd0, 3'b001, 1'b0, 3'b000});
  endtask

  initial begin
    rst = 1'b1; idle = 1'b1; p_acc = 3'b000; p_we = 3'b000; ctl_en = 3'b000; rr_watch = 1'b0;
    p_adr = {32'h40, 32'h200, 32'h100};
    p_dat = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
    p_sel = {4'hF, 4'h2, 4'h1};
    p_bufw = {4'h5, 4'h2, 4'h1};

    // idle after reset: owner port0, no request, no snoop
    reset_all();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_hold", {a_grant, a_acc, a_snp_we}, {3'b001, 1'b0, 3'b000});
    end

    // RR with limit 2: owners 010,100,001,010, two acks each
    reset_all();
    ctl_en = 3'b001; rr_watch = 1'b1;
    a_q.push_back(3'b010); a_q.push_back(3'b010); a_q.push_back(3'b100); a_q.push_back(3'b100);
    a_q.push_back(3'b001); a_q.push_back(3'b001); a_q.push_back(3'b010); a_q.push_back(3'b010);
    p_acc = 3'b111;
    wait_q(0, 0, 80);
    p_acc = 3'b000; rr_watch = 1'b0;

    // PRIO: port1 keeps grant when port0 arrives mid-burst, then port0 beats port2
    reset_all();
    ctl_en = 3'b010;
    b_q.push_back(3'b010); b_q.push_back(3'b010); b_q.push_back(3'b001); b_q.push_back(3'b001);
    p_acc = 3'b110;
    wait_q(1, 3, 20);
    p_acc = 3'b111;
    wait_q(1, 0, 40);
    p_acc = 3'b000;

    // port2 write: mux follows grant, snoop strobes the other two ports
    reset_all();
    ctl_en = 3'b001; p_we = 3'b100;
    a_q.push_back(3'b100);
    snp_q.push_back({3'b011, 32'h40, 32'hDEADBEEF, 4'hF});
    p_acc = 3'b100;
    @(posedge clk); #1;
    check("mux_port2", {a_grant, a_adr, a_dat, a_sel, a_we, a_bufw},
          {3'b100, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 4'h5});
    wait_q(0, 0, 20);
    p_acc = 3'b000;
    @(posedge clk); @(posedge clk); #1;
    check("snoop_done", snp_q.size(), 0);

    // owner releases while controller busy: DRAIN holds, grant frozen, no request out
    reset_all();
    ctl_en = 3'b001;
    a_q.push_back(3'b010);
    p_acc = 3'b010;
    wait_q(0, 0, 20);
    idle = 1'b0; p_acc = 3'b101;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("drain_hold", {a_state, a_grant, a_acc}, {2'd2, 3'b010, 1'b0});
    end
    idle = 1'b1;
    @(posedge clk); #1;
    check("drain_exit", {a_state, a_grant}, {2'd1, 3'b100});
    ctl_en = 3'b000; p_acc = 3'b000;

    // reset while owning drops everything back to reset values
    reset_all();
    p_acc = 3'b010;
    @(posedge clk); #1;
    check("own_pre_rst", {a_state, a_grant, a_acc}, {2'd1, 3'b010, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", {a_state, a_grant, a_acc}, {2'd0, 3'b001, 1'b0});
    rst = 1'b0; p_acc = 3'b000;

    // unlimited grant: port1 alone for 100 acks, never drains
    reset_all();
    ctl_en = 3'b100;
    for (int i = 0; i < 100; i++) c_q.push_back(3'b010);
    p_acc = 3'b010;
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      check("unl_own", {c_state, c_acc}, {2'd1, 1'b1});
      if (c_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("unl_done", c_q.size(), 0);
    p_acc = 3'b000; ctl_en = 3'b000;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
